gauss_window_fetch: RTL and testbench
=====================================

Name: gauss_window_fetch

Overview:
- Downstream of the grayscale conversion stage; sits in front of the Gaussian blur compute.
- On each start request, reads a kernel_size x kernel_size neighbourhood around (center_x, center_y) from the grayscale SRAM, one pixel per cycle.
- Replicates edge pixels for out-of-image coordinates.
- Presents the neighbourhood as a flattened MAX_KERNEL x MAX_KERNEL matrix with a one-cycle valid pulse.

Parameters:
- X_MAX, 200, maximum image width.
- Y_MAX, 200, maximum image height.
- PIXEL_DEPTH, 8, bits per grayscale pixel.
- MAX_KERNEL, 5, largest supported kernel edge; must be odd.

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  fetch request; sampled only in IDLE.
- center_x  in  $clog2(X_MAX)  window centre column.
- center_y  in  $clog2(Y_MAX)  window centre row.
- kernel_size  in  $clog2(MAX_KERNEL)+1  window edge; legal values are odd, 1..MAX_KERNEL.
- max_x  in  $clog2(X_MAX)  last valid column index (inclusive).
- max_y  in  $clog2(Y_MAX)  last valid row index (inclusive).
- x_addr  out  $clog2(X_MAX)+1  SRAM column address.
- y_addr  out  $clog2(Y_MAX)+1  SRAM row address.
- ren  out  1  SRAM read enable.
- rdat  in  PIXEL_DEPTH  SRAM read data; valid the cycle after ren.
- window  out  MAX_KERNEL*MAX_KERNEL*PIXEL_DEPTH  flattened matrix.
- window_valid  out  1  one-cycle pulse; window is complete.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse; illegal kernel_size at start.

Behaviour:
- Reset: state IDLE; all outputs 0, including window, x_addr, y_addr, ren, window_valid, busy, err. Internal counters 0.
- An asserted reset mid-fetch aborts the fetch immediately. No window_valid follows.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start with a legal k latches center_x, center_y, k, max_x and max_y, zeroes window, and goes to ISSUE.
  - start with an illegal k (even, 0, or > MAX_KERNEL) pulses err for one cycle next cycle and stays IDLE. No reads are issued.
- ISSUE:
  - ren=1 for exactly k*k consecutive cycles.
  - Positions are visited row-major: row i = 0..k-1 top to bottom, column j = 0..k-1 left to right.
  - Address: x = cx + j - k/2 and y = cy + i - k/2, computed signed at width $clog2(X_MAX)+2 (respectively $clog2(Y_MAX)+2).
  - Clamp: values < 0 become 0; values > max becomes max (edge replicate).
  - After the last issue, go to DRAIN.
- Capture: each cycle following an issue, rdat is written to window element index i*MAX_KERNEL+j, bits [(idx+1)*PIXEL_DEPTH-1 : idx*PIXEL_DEPTH]. Row 0 is the top row. The capture pipeline register carries (i,j).
- DRAIN: ren=0; captures the final pixel; go to DONE.
- DONE: window_valid=1 for one cycle; go to IDLE.
- Latency: start sampled at cycle T, first ren at T+1, window_valid at T+k*k+2.
- Elements with i >= k or j >= k read 0.
- The window holds its value until the next legal start clears it.
- start while busy is ignored, with no queueing.
- A start in the same cycle as DONE is ignored; accept it from IDLE on the next cycle.
- k=1: a single read, window_valid at T+3.
- Coordinate inputs are not re-sampled during a fetch; changes after start have no effect.
- x_addr and y_addr hold their last value when ren=0.

Decomposition:
- Package gauss_window_pkg:
  - state enum WIN_STATE (IDLE, ISSUE, DRAIN, DONE, 2-bit);
  - localparam for window width;
  - function clamp_coord(signed value, max) -> unsigned.
- Sub-module window_addr_gen:
  - row/column counters, clamped address generation, last-issue flag;
  - inputs load, advance, cx, cy, k, max_x, max_y;
  - outputs x_addr, y_addr, cur_i, cur_j, last.
- Top level holds the FSM, capture pipeline and window register.

Test Plan:
- Common setup: SRAM model returns (y*16+x)&0xFF with 1-cycle latency; max_x=max_y=9; MAX_KERNEL=5.
- Interior fetch: k=3, centre (4,4) -> 9 ren cycles; window row0 = 0x33,0x34,0x35, row1 = 0x43,0x44,0x45, row2 = 0x53,0x54,0x55; elements with i or j >= 3 are 0; window_valid exactly 11 cycles after start.
- Corner clamp: k=5, centre (0,0) -> addresses never negative; row0 = 0x00,0x00,0x00,0x01,0x02; row4 = 0x20,0x20,0x20,0x21,0x22; window_valid 27 cycles after start.
- Far-edge clamp: k=3, centre (9,9) -> x and y never exceed 9; element (2,2) = 0x99; element (0,0) = 0x88.
- Illegal size: k=4 and k=7 -> err pulse 1 cycle, ren never high, busy stays 0, window unchanged.
- Busy collision: second start (k=1, centre (2,2)) asserted 3 cycles into a k=3 fetch -> ignored; only one window_valid, with the k=3 content.
- Reset mid-fetch: n_rst low at the 5th ISSUE cycle -> ren, busy, window all 0 immediately; no window_valid; a fresh k=1 fetch at centre (2,2) then returns 0x22 at T+3.

Source files
------------

// File: rtl/gauss_window_pkg.sv
`default_nettype none
// ============================================================================
// Module : gauss_window_pkg
// Brief  : Shared types, default sizes and coordinate clamp for the window fetch.
// Rev    : 1.0  initial release
// ============================================================================
package gauss_window_pkg;

  localparam int c_x_max       = 200;
  localparam int c_y_max       = 200;
  localparam int c_pixel_depth = 8;
  localparam int c_max_kernel  = 5;
  localparam int c_win_w       = c_max_kernel * c_max_kernel * c_pixel_depth;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } WIN_STATE;

  // Edge replication: out-of-image coordinates snap to the nearest border.
  function automatic int unsigned clamp_coord(input int value, input int max_v);
    if (value < 0)
      return 0;
    if (value > max_v)
      return max_v;
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gauss_window_fetch_if.sv
`default_nettype none
// ============================================================================
// Module : gauss_window_fetch_if
// Brief  : Request, SRAM read and window result signals of the window fetch.
// Rev    : 1.0  initial release
// ============================================================================
interface gauss_window_fetch_if #(
  parameter int X_MAX       = gauss_window_pkg::c_x_max,
  parameter int Y_MAX       = gauss_window_pkg::c_y_max,
  parameter int PIXEL_DEPTH = gauss_window_pkg::c_pixel_depth,
  parameter int MAX_KERNEL  = gauss_window_pkg::c_max_kernel
);
  localparam int c_xw = $clog2(X_MAX);
  localparam int c_yw = $clog2(Y_MAX);
  localparam int c_kw = $clog2(MAX_KERNEL) + 1;
  localparam int c_ww = MAX_KERNEL * MAX_KERNEL * PIXEL_DEPTH;

  logic                   start;
  logic [c_xw-1:0]        center_x;
  logic [c_yw-1:0]        center_y;
  logic [c_kw-1:0]        kernel_size;
  logic [c_xw-1:0]        max_x;
  logic [c_yw-1:0]        max_y;
  logic [c_xw:0]          x_addr;
  logic [c_yw:0]          y_addr;
  logic                   ren;
  logic [PIXEL_DEPTH-1:0] rdat;
  logic [c_ww-1:0]        window;
  logic                   window_valid;
  logic                   busy;
  logic                   err;

  modport slave (
    input  start, center_x, center_y, kernel_size, max_x, max_y, rdat,
    output x_addr, y_addr, ren, window, window_valid, busy, err
  );

  modport master (
    output start, center_x, center_y, kernel_size, max_x, max_y, rdat,
    input  x_addr, y_addr, ren, window, window_valid, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/window_addr_gen.sv
`default_nettype none
// ============================================================================
// Module : window_addr_gen
// Brief  : Row-major window walker producing clamped SRAM addresses.
// Rev    : 1.0  initial release
// ============================================================================
module window_addr_gen
  import gauss_window_pkg::*;
#(
  parameter int X_MAX      = c_x_max,
  parameter int Y_MAX      = c_y_max,
  parameter int MAX_KERNEL = c_max_kernel
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          load,
  input  logic                          advance,
  input  logic [$clog2(X_MAX)-1:0]      cx,
  input  logic [$clog2(Y_MAX)-1:0]      cy,
  input  logic [$clog2(MAX_KERNEL):0]   k,
  input  logic [$clog2(X_MAX)-1:0]      max_x,
  input  logic [$clog2(Y_MAX)-1:0]      max_y,
  output logic [$clog2(X_MAX):0]        x_addr,
  output logic [$clog2(Y_MAX):0]        y_addr,
  output logic [$clog2(MAX_KERNEL)-1:0] cur_i,
  output logic [$clog2(MAX_KERNEL)-1:0] cur_j,
  output logic                          last
);
  localparam int c_xw  = $clog2(X_MAX);
  localparam int c_yw  = $clog2(Y_MAX);
  localparam int c_kw  = $clog2(MAX_KERNEL) + 1;
  localparam int c_cw  = $clog2(MAX_KERNEL);
  localparam int c_xcw = c_xw + 2;
  localparam int c_ycw = c_yw + 2;
  localparam int c_xaw = c_xw + 1;
  localparam int c_yaw = c_yw + 1;

  logic [c_xw-1:0] r_cx, r_max_x;
  logic [c_yw-1:0] r_cy, r_max_y;
  logic [c_kw-1:0] r_k;
  logic [c_cw-1:0] r_i, r_j;

  logic [c_kw-1:0]         w_k_m1, w_half;
  logic                    w_i_last, w_j_last;
  logic signed [c_xcw-1:0] w_sx;
  logic signed [c_ycw-1:0] w_sy;

  assign w_k_m1   = r_k - 1'b1;
  assign w_half   = r_k >> 1;
  assign w_i_last = ({{(c_kw-c_cw){1'b0}}, r_i} == w_k_m1);
  assign w_j_last = ({{(c_kw-c_cw){1'b0}}, r_j} == w_k_m1);

  // Counters park on the final position so the address holds once reads stop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cx    <= '0;
      r_cy    <= '0;
      r_k     <= '0;
      r_max_x <= '0;
      r_max_y <= '0;
      r_i     <= '0;
      r_j     <= '0;
    end else if (load) begin
      r_cx    <= cx;
      r_cy    <= cy;
      r_k     <= k;
      r_max_x <= max_x;
      r_max_y <= max_y;
      r_i     <= '0;
      r_j     <= '0;
    end else if (advance) begin
      if (w_j_last) begin
        r_j <= '0;
        r_i <= r_i + 1'b1;
      end else begin
        r_j <= r_j + 1'b1;
      end
    end
  end

  assign w_sx = $signed({2'b00, r_cx}) + $signed({{(c_xcw-c_cw){1'b0}}, r_j})
              - $signed({{(c_xcw-c_kw){1'b0}}, w_half});
  assign w_sy = $signed({2'b00, r_cy}) + $signed({{(c_ycw-c_cw){1'b0}}, r_i})
              - $signed({{(c_ycw-c_kw){1'b0}}, w_half});

  assign x_addr = c_xaw'(clamp_coord(int'(w_sx), int'(r_max_x)));
  assign y_addr = c_yaw'(clamp_coord(int'(w_sy), int'(r_max_y)));
  assign cur_i  = r_i;
  assign cur_j  = r_j;
  assign last   = w_i_last && w_j_last;

endmodule
`default_nettype wire

// File: rtl/gauss_window_fetch.sv
`default_nettype none
// ============================================================================
// Module : gauss_window_fetch
// Brief  : Fetches a k x k edge-replicated neighbourhood for the Gaussian blur.
// Rev    : 1.0  initial release
// ============================================================================
module gauss_window_fetch
  import gauss_window_pkg::*;
#(
  parameter int X_MAX       = c_x_max,
  parameter int Y_MAX       = c_y_max,
  parameter int PIXEL_DEPTH = c_pixel_depth,
  parameter int MAX_KERNEL  = c_max_kernel
) (
  input logic                 clk,
  input logic                 n_rst,
  gauss_window_fetch_if.slave bus
);
  localparam int c_kw = $clog2(MAX_KERNEL) + 1;
  localparam int c_cw = $clog2(MAX_KERNEL);
  localparam int c_n  = MAX_KERNEL * MAX_KERNEL;
  localparam int c_ww = c_n * PIXEL_DEPTH;

  WIN_STATE r_state, w_next;

  logic            w_k_legal, w_load, w_advance, w_ren, w_busy, w_valid, w_last;
  logic            r_err, r_cap_valid;
  logic [c_cw-1:0] w_cur_i, w_cur_j, r_cap_i, r_cap_j;
  int              w_cap_idx;

  logic [PIXEL_DEPTH-1:0] r_win [c_n];
  logic [c_ww-1:0]        w_window;

  assign w_k_legal = bus.kernel_size[0] && (bus.kernel_size <= c_kw'(MAX_KERNEL));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start && w_k_legal) w_next = ISSUE;
      ISSUE:   if (w_last) w_next = DRAIN;
      DRAIN:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_ren     = (r_state == ISSUE);
    w_busy    = (r_state != IDLE);
    w_valid   = (r_state == DONE);
    w_load    = (r_state == IDLE) && bus.start && w_k_legal;
    w_advance = (r_state == ISSUE) && !w_last;
  end

  window_addr_gen #(
    .X_MAX      (X_MAX),
    .Y_MAX      (Y_MAX),
    .MAX_KERNEL (MAX_KERNEL)
  ) u_addr_gen (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (w_load),
    .advance (w_advance),
    .cx      (bus.center_x),
    .cy      (bus.center_y),
    .k       (bus.kernel_size),
    .max_x   (bus.max_x),
    .max_y   (bus.max_y),
    .x_addr  (bus.x_addr),
    .y_addr  (bus.y_addr),
    .cur_i   (w_cur_i),
    .cur_j   (w_cur_j),
    .last    (w_last)
  );

  // Position of each read travels one cycle to line up with the SRAM data.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cap_valid <= 1'b0;
      r_cap_i     <= '0;
      r_cap_j     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_cap_valid <= w_ren;
      r_cap_i     <= w_cur_i;
      r_cap_j     <= w_cur_j;
      r_err       <= (r_state == IDLE) && bus.start && !w_k_legal;
    end
  end

  always_comb begin
    w_cap_idx = int'(r_cap_i) * MAX_KERNEL + int'(r_cap_j);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int e = 0; e < c_n; e++)
        r_win[e] <= '0;
    end else if (w_load) begin
      for (int e = 0; e < c_n; e++)
        r_win[e] <= '0;
    end else if (r_cap_valid) begin
      for (int e = 0; e < c_n; e++)
        if (e == w_cap_idx)
          r_win[e] <= bus.rdat;
    end
  end

  always_comb begin
    w_window = '0;
    for (int e = 0; e < c_n; e++)
      w_window[e*PIXEL_DEPTH +: PIXEL_DEPTH] = r_win[e];
  end

  assign bus.ren          = w_ren;
  assign bus.busy         = w_busy;
  assign bus.window_valid = w_valid;
  assign bus.err          = r_err;
  assign bus.window       = w_window;

endmodule
`default_nettype wire

// File: tb/tb_gauss_window_fetch.sv
`default_nettype none
// ============================================================================
// Module : tb_gauss_window_fetch
// Brief  : Self-checking bench for gauss_window_fetch against a window model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gauss_window_fetch;
  import gauss_window_pkg::*;

  localparam int c_mk = c_max_kernel;
  localparam int c_pd = c_pixel_depth;
  localparam int c_ww = c_win_w;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  gauss_window_fetch_if bus ();

  gauss_window_fetch dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Image content: pixel (x,y) = (y*16 + x) & 0xFF, one-cycle read latency.
  always @(posedge clk)
    if (bus.ren)
      bus.rdat <= 8'((int'(bus.y_addr) * 16 + int'(bus.x_addr)) & 255);

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int clip(input int v, input int m);
    return (v < 0) ? 0 : ((v > m) ? m : v);
  endfunction

  function automatic logic [c_ww-1:0] model_window(input int cx, input int cy, input int k,
                                                   input int mx, input int my);
    logic [c_ww-1:0] w;
    w = '0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        w[(i*c_mk+j)*c_pd +: c_pd] = 8'((clip(cy+i-k/2, my) * 16 + clip(cx+j-k/2, mx)) & 255);
    return w;
  endfunction

  function automatic logic [7:0] elem(input logic [c_ww-1:0] w, input int i, input int j);
    return w[(i*c_mk+j)*c_pd +: c_pd];
  endfunction

  task automatic drive_req(input int cx, input int cy, input int k, input int mx, input int my);
    bus.center_x    = 8'(cx);
    bus.center_y    = 8'(cy);
    bus.kernel_size = 4'(k);
    bus.max_x       = 8'(mx);
    bus.max_y       = 8'(my);
    bus.start       = 1'b1;
  endtask

  task automatic run_fetch(input string tag, input int cx, input int cy, input int k,
                           input int mx, input int my);
    int lat, ren_cnt, bad;
    logic [c_ww-1:0] exp;
    exp = model_window(cx, cy, k, mx, my);
    @(negedge clk);
    drive_req(cx, cy, k, mx, my);
    @(negedge clk);
    bus.start = 1'b0;
    // Inputs after acceptance must not influence the fetch.
    bus.center_x    = 8'($urandom);
    bus.center_y    = 8'($urandom);
    bus.max_x       = 8'($urandom);
    bus.max_y       = 8'($urandom);
    bus.kernel_size = 4'($urandom);
    lat = 1; ren_cnt = 0; bad = 0;
    while (!bus.window_valid && lat < 100) begin
      if (bus.ren) begin
        ren_cnt++;
        if (int'(bus.x_addr) > mx || int'(bus.y_addr) > my)
          bad++;
      end
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 256'(lat), 256'(k*k+2));
    check({tag, " ren_cycles"}, 256'(ren_cnt), 256'(k*k));
    check({tag, " addr_range"}, 256'(bad), 256'(0));
    check({tag, " window"}, 256'(bus.window), 256'(exp));
    @(negedge clk);
    check({tag, " valid_pulse"}, 256'(bus.window_valid), 256'(0));
  endtask

  initial begin
    int lat, cnt, err_cnt, ren_seen, busy_seen, first_lat;
    logic [c_ww-1:0] hold, got, exp;
    int k, mx, my, cx, cy;

    bus.start = 1'b0; bus.center_x = '0; bus.center_y = '0;
    bus.kernel_size = '0; bus.max_x = '0; bus.max_y = '0;

    repeat (3) @(negedge clk);
    check("rst ren",    256'(bus.ren),          256'(0));
    check("rst busy",   256'(bus.busy),         256'(0));
    check("rst valid",  256'(bus.window_valid), 256'(0));
    check("rst err",    256'(bus.err),          256'(0));
    check("rst window", 256'(bus.window),       256'(0));
    check("rst xy",     256'({bus.x_addr, bus.y_addr}), 256'(0));
    n_rst = 1'b1;

    run_fetch("interior", 4, 4, 3, 9, 9);
    check("interior e00", 256'(elem(bus.window, 0, 0)), 256'(8'h33));
    check("interior e11", 256'(elem(bus.window, 1, 1)), 256'(8'h44));
    check("interior e22", 256'(elem(bus.window, 2, 2)), 256'(8'h55));
    check("interior e03", 256'(elem(bus.window, 0, 3)), 256'(0));
    check("interior e40", 256'(elem(bus.window, 4, 0)), 256'(0));

    run_fetch("corner", 0, 0, 5, 9, 9);
    check("corner e03", 256'(elem(bus.window, 0, 3)), 256'(8'h01));
    check("corner e40", 256'(elem(bus.window, 4, 0)), 256'(8'h20));
    check("corner e44", 256'(elem(bus.window, 4, 4)), 256'(8'h22));

    run_fetch("far_edge", 9, 9, 3, 9, 9);
    check("far e22", 256'(elem(bus.window, 2, 2)), 256'(8'h99));
    check("far e00", 256'(elem(bus.window, 0, 0)), 256'(8'h88));

    for (int t = 0; t < 2; t++) begin
      hold = bus.window;
      @(negedge clk);
      drive_req(4, 4, (t == 0) ? 4 : 7, 9, 9);
      @(negedge clk);
      bus.start = 1'b0;
      check("illegal err_next", 256'(bus.err), 256'(1));
      err_cnt = 0; ren_seen = 0; busy_seen = 0;
      for (int c = 0; c < 6; c++) begin
        err_cnt   += int'(bus.err);
        ren_seen  += int'(bus.ren);
        busy_seen += int'(bus.busy);
        @(negedge clk);
      end
      check("illegal err_count", 256'(err_cnt), 256'(1));
      check("illegal ren", 256'(ren_seen), 256'(0));
      check("illegal busy", 256'(busy_seen), 256'(0));
      check("illegal window", 256'(bus.window), 256'(hold));
    end

    exp = model_window(3, 5, 3, 9, 9);
    @(negedge clk);
    drive_req(3, 5, 3, 9, 9);
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0; first_lat = 0; got = '0;
    for (lat = 1; lat <= 40; lat++) begin
      if (lat == 3) drive_req(2, 2, 1, 9, 9);
      if (lat == 4) bus.start = 1'b0;
      if (bus.window_valid) begin
        cnt++;
        if (first_lat == 0) begin
          first_lat = lat;
          got = bus.window;
        end
      end
      @(negedge clk);
    end
    check("collision valid_count", 256'(cnt), 256'(1));
    check("collision latency", 256'(first_lat), 256'(11));
    check("collision window", 256'(got), 256'(exp));

    @(negedge clk);
    drive_req(4, 4, 5, 9, 9);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst ren_before", 256'(bus.ren), 256'(1));
    n_rst = 1'b0;
    #1;
    check("midrst ren", 256'(bus.ren), 256'(0));
    check("midrst busy", 256'(bus.busy), 256'(0));
    check("midrst window", 256'(bus.window), 256'(0));
    @(negedge clk);
    n_rst = 1'b1;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      cnt += int'(bus.window_valid);
      @(negedge clk);
    end
    check("midrst no_valid", 256'(cnt), 256'(0));
    run_fetch("after_rst", 2, 2, 1, 9, 9);
    check("after_rst e00", 256'(elem(bus.window, 0, 0)), 256'(8'h22));

    for (int it = 0; it < 16; it++) begin
      k  = 2 * int'($urandom_range(0, 2)) + 1;
      mx = int'($urandom_range(2, 15));
      my = int'($urandom_range(2, 15));
      cx = int'($urandom_range(0, mx));
      cy = int'($urandom_range(0, my));
      run_fetch($sformatf("rand%0d", it), cx, cy, k, mx, my);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
